vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 151 +++++++++++++++
 tb/tb_vram_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Three-channel VRAM arbiter: fixed priority ch0 > ch1 > ch2 with starvation
// escalation for ch1/ch2, byte writes, word reads returned one cycle after issue.
module vram_arbiter #(
    parameter int unsigned STARVE1 = 4,
    parameter int unsigned STARVE2 = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ch0_req,
    input  logic [16:0] ch0_addr,
    input  logic        ch0_write,
    input  logic [7:0]  ch0_wrdata,
    output logic        ch0_ack,
    output logic        ch0_rdvalid,

    input  logic        ch1_req,
    input  logic [16:0] ch1_addr,
    input  logic        ch1_write,
    input  logic [7:0]  ch1_wrdata,
    output logic        ch1_ack,
    output logic        ch1_rdvalid,

    input  logic        ch2_req,
    input  logic [16:0] ch2_addr,
    input  logic        ch2_write,
    input  logic [7:0]  ch2_wrdata,
    output logic        ch2_ack,
    output logic        ch2_rdvalid,

    output logic [14:0] ram_addr,
    output logic [3:0]  ram_wrbytesel,
    output logic [31:0] ram_wrdata,
    output logic        ram_write,
    input  logic [31:0] ram_rddata
);

    localparam int unsigned CW1 = (STARVE1 < 1) ? 1 : $clog2(STARVE1 + 1);
    localparam int unsigned CW2 = (STARVE2 < 1) ? 1 : $clog2(STARVE2 + 1);
    localparam logic [CW1-1:0] LIM1 = CW1'(STARVE1);
    localparam logic [CW2-1:0] LIM2 = CW2'(STARVE2);

    logic [CW1-1:0] cnt1_q, cnt1_d;
    logic [CW2-1:0] cnt2_q, cnt2_d;
    logic [2:0]     gnt;
    logic [2:0]     rd_q, rd_d;
    logic [14:0]    last_addr_q;

    logic [16:0]    sel_addr;
    logic           sel_write;
    logic [7:0]     sel_wrdata;
    logic           any_gnt;
    logic           wr_issue;

    // Read data is returned by the RAM directly to the requesters.
    logic unused_rddata;
    assign unused_rddata = ^ram_rddata;

    // Starved channels preempt fixed priority; ch1 wins a joint starvation.
    always_comb begin
        gnt = 3'b000;
        if (!rst) begin
            if (ch1_req && cnt1_q == LIM1) begin
                gnt = 3'b010;
            end else if (ch2_req && cnt2_q == LIM2) begin
                gnt = 3'b100;
            end else if (ch0_req) begin
                gnt = 3'b001;
            end else if (ch1_req) begin
                gnt = 3'b010;
            end else if (ch2_req) begin
                gnt = 3'b100;
            end
        end
    end

    always_comb begin
        sel_addr   = 17'd0;
        sel_write  = 1'b0;
        sel_wrdata = 8'd0;
        if (gnt[0]) begin
            sel_addr   = ch0_addr;
            sel_write  = ch0_write;
            sel_wrdata = ch0_wrdata;
        end else if (gnt[1]) begin
            sel_addr   = ch1_addr;
            sel_write  = ch1_write;
            sel_wrdata = ch1_wrdata;
        end else if (gnt[2]) begin
            sel_addr   = ch2_addr;
            sel_write  = ch2_write;
            sel_wrdata = ch2_wrdata;
        end
    end

    assign any_gnt  = |gnt;
    assign wr_issue = any_gnt & sel_write;

    always_comb begin
        rd_d[0] = gnt[0] & ~ch0_write;
        rd_d[1] = gnt[1] & ~ch1_write;
        rd_d[2] = gnt[2] & ~ch2_write;
    end

    // A dropped request clears its counter just like a grant does.
    always_comb begin
        cnt1_d = cnt1_q;
        if (!ch1_req || gnt[1]) begin
            cnt1_d = '0;
        end else if (cnt1_q != LIM1) begin
            cnt1_d = cnt1_q + CW1'(1);
        end
        cnt2_d = cnt2_q;
        if (!ch2_req || gnt[2]) begin
            cnt2_d = '0;
        end else if (cnt2_q != LIM2) begin
            cnt2_d = cnt2_q + CW2'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            rd_q        <= 3'b000;
            last_addr_q <= 15'd0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
            rd_q   <= rd_d;
            if (any_gnt) begin
                last_addr_q <= sel_addr[16:2];
            end
        end
    end

    assign ch0_ack = gnt[0];
    assign ch1_ack = gnt[1];
    assign ch2_ack = gnt[2];

    // Gating with rst squashes a read return that lands in a reset cycle.
    assign ch0_rdvalid = rd_q[0] & ~rst;
    assign ch1_rdvalid = rd_q[1] & ~rst;
    assign ch2_rdvalid = rd_q[2] & ~rst;

    assign ram_addr      = rst ? 15'd0 : (any_gnt ? sel_addr[16:2] : last_addr_q);
    assign ram_write     = wr_issue;
    assign ram_wrbytesel = wr_issue ? (4'b0001 << sel_addr[1:0]) : 4'b0000;
    assign ram_wrdata    = wr_issue ? {4{sel_wrdata}} : 32'd0;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: per-cycle comparison against a behavioural model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vram_arbiter;

    localparam int S1 = 4;
    localparam int S2 = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req [3];
    logic [16:0] addr [3];
    logic        wr [3];
    logic [7:0]  wdata [3];
    logic        ack [3];
    logic        rdv [3];
    logic [14:0] ram_addr;
    logic [3:0]  ram_wrbytesel;
    logic [31:0] ram_wrdata;
    logic        ram_write;
    logic [31:0] ram_rddata;

    always #5 clk = ~clk;

    vram_arbiter #(.STARVE1(S1), .STARVE2(S2)) dut (
        .clk(clk), .rst(rst),
        .ch0_req(req[0]), .ch0_addr(addr[0]), .ch0_write(wr[0]), .ch0_wrdata(wdata[0]),
        .ch0_ack(ack[0]), .ch0_rdvalid(rdv[0]),
        .ch1_req(req[1]), .ch1_addr(addr[1]), .ch1_write(wr[1]), .ch1_wrdata(wdata[1]),
        .ch1_ack(ack[1]), .ch1_rdvalid(rdv[1]),
        .ch2_req(req[2]), .ch2_addr(addr[2]), .ch2_write(wr[2]), .ch2_wrdata(wdata[2]),
        .ch2_ack(ack[2]), .ch2_rdvalid(rdv[2]),
        .ram_addr(ram_addr), .ram_wrbytesel(ram_wrbytesel), .ram_wrdata(ram_wrdata),
        .ram_write(ram_write), .ram_rddata(ram_rddata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: wait counts, last word address, channel owed a read return.
    int wait1 = 0;
    int wait2 = 0;
    int last_word = 0;
    int pend_rd = -1;
    int m_gnt = -1;

    // Values sampled from the DUT at the most recent negedge.
    logic [2:0]  s_ack;
    logic [2:0]  s_rdv;
    logic [14:0] s_addr;
    logic        s_wr;
    logic [3:0]  s_bsel;
    logic [31:0] s_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int model_grant();
        if (rst) return -1;
        if (req[1] && wait1 == S1) return 1;
        if (req[2] && wait2 == S2) return 2;
        for (int i = 0; i < 3; i++) if (req[i]) return i;
        return -1;
    endfunction

    // One clock cycle: compare every output with the model, then advance it.
    task automatic step();
        int g;
        int e_addr, e_bsel, e_rdv, e_ack;
        logic [31:0] e_wdata;
        @(negedge clk);
        s_ack   = {ack[2], ack[1], ack[0]};
        s_rdv   = {rdv[2], rdv[1], rdv[0]};
        s_addr  = ram_addr;
        s_wr    = ram_write;
        s_bsel  = ram_wrbytesel;
        s_wdata = ram_wrdata;

        g = model_grant();
        e_ack = (g >= 0) ? (1 << g) : 0;
        e_rdv = (!rst && pend_rd >= 0) ? (1 << pend_rd) : 0;
        e_addr = rst ? 0 : ((g >= 0) ? int'(addr[g]) / 4 : last_word);
        e_bsel = 0;
        e_wdata = 32'd0;
        if (g >= 0 && wr[g]) begin
            e_bsel  = 1 << (int'(addr[g]) % 4);
            e_wdata = 32'(wdata[g]) * 32'h0101_0101;
        end
        check("ack", 32'(s_ack), 32'(e_ack));
        check("rdvalid", 32'(s_rdv), 32'(e_rdv));
        check("ram_addr", 32'(s_addr), 32'(e_addr));
        check("ram_write", 32'(s_wr), (g >= 0 && wr[g]) ? 32'd1 : 32'd0);
        check("ram_wrbytesel", 32'(s_bsel), 32'(e_bsel));
        check("ram_wrdata", s_wdata, e_wdata);

        m_gnt = g;
        if (rst) begin
            wait1 = 0; wait2 = 0; last_word = 0; pend_rd = -1;
        end else begin
            wait1 = (!req[1] || g == 1) ? 0 : ((wait1 < S1) ? wait1 + 1 : S1);
            wait2 = (!req[2] || g == 2) ? 0 : ((wait2 < S2) ? wait2 + 1 : S2);
            if (g >= 0) last_word = int'(addr[g]) / 4;
            pend_rd = (g >= 0 && !wr[g]) ? g : -1;
        end
        @(posedge clk);
        #1;
        ram_rddata = $urandom;
    endtask

    task automatic set_req(input int ch, input logic [16:0] a, input logic w, input logic [7:0] d);
        req[ch] = 1'b1; addr[ch] = a; wr[ch] = w; wdata[ch] = d;
    endtask

    task automatic clear_all();
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; addr[i] = 17'd0; wr[i] = 1'b0; wdata[i] = 8'd0;
        end
    endtask

    initial begin
        logic [9:0]  ch1_pat;
        logic [11:0] ch1_pat3;
        int          ch2_first;

        rst = 1'b1;
        ram_rddata = 32'd0;
        clear_all();
        set_req(1, 17'h00010, 1'b0, 8'h00);
        step();
        step();
        check("reset_ack", 32'(s_ack), 32'd0);
        check("reset_addr", 32'(s_addr), 32'd0);
        rst = 1'b0;
        clear_all();
        step();

        // Lone ch1 byte write.
        set_req(1, 17'h1F9C2, 1'b1, 8'hFF);
        step();
        check("lit_w_ack", 32'(s_ack), 32'b010);
        check("lit_w_addr", 32'(s_addr), 32'h7E70);
        check("lit_w_bsel", 32'(s_bsel), 32'b0100);
        check("lit_w_data", s_wdata, 32'hFFFF_FFFF);
        check("lit_w_write", 32'(s_wr), 32'd1);
        clear_all();
        step();
        check("idle_holds_addr", 32'(s_addr), 32'h7E70);

        // ch0 + ch1 held: ch1 gets every fifth cycle.
        set_req(0, 17'h00100, 1'b0, 8'h00);
        set_req(1, 17'h00200, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            step();
            ch1_pat[i] = s_ack[1];
        end
        check("lit_starve1_pattern", 32'(ch1_pat), 32'h210);
        clear_all();
        step();

        // All three held: ch2 no later than the ninth cycle, ch1 keeps its bound.
        set_req(0, 17'h00100, 1'b0, 8'h00);
        set_req(1, 17'h00200, 1'b0, 8'h00);
        set_req(2, 17'h00300, 1'b0, 8'h00);
        ch2_first = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            ch1_pat3[i] = s_ack[1];
            if (s_ack[2] && ch2_first < 0) ch2_first = i;
        end
        check("lit_starve2_first", 32'(ch2_first), 32'd8);
        check("lit_starve2_ch1", 32'(ch1_pat3), 32'h210);
        clear_all();
        step();

        // Joint limit: ch1 wins, ch2 follows next cycle.
        set_req(0, 17'h00100, 1'b0, 8'h00);
        set_req(2, 17'h00300, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step();
        set_req(1, 17'h00200, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step();
        step();
        check("lit_joint_ch1", 32'(s_ack), 32'b010);
        step();
        check("lit_joint_ch2", 32'(s_ack), 32'b100);
        clear_all();
        step();

        // Back-to-back reads on different channels.
        set_req(0, 17'h00004, 1'b0, 8'h00);
        step();
        check("lit_rd0_ack", 32'(s_ack), 32'b001);
        clear_all();
        set_req(2, 17'h00008, 1'b0, 8'h00);
        step();
        check("lit_rd0_valid", 32'(s_rdv), 32'b001);
        check("lit_rd2_ack", 32'(s_ack), 32'b100);
        clear_all();
        step();
        check("lit_rd2_valid", 32'(s_rdv), 32'b100);

        // Reset right after a read grant; pending ch1 acked on release.
        set_req(0, 17'h00040, 1'b0, 8'h00);
        step();
        clear_all();
        set_req(1, 17'h00044, 1'b1, 8'h5A);
        rst = 1'b1;
        step();
        check("lit_rst_rdv", 32'(s_rdv), 32'd0);
        check("lit_rst_ack", 32'(s_ack), 32'd0);
        check("lit_rst_addr", 32'(s_addr), 32'd0);
        check("lit_rst_bsel", 32'({s_wr, s_bsel}), 32'd0);
        rst = 1'b0;
        step();
        check("lit_rel_ack", 32'(s_ack), 32'b010);
        clear_all();
        step();

        // Randomized requesters: hold until ack, occasionally drop, rare resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst = ($urandom_range(0, 99) == 0);
            step();
            for (int c = 0; c < 3; c++) begin
                if (req[c] && m_gnt != c && $urandom_range(0, 19) != 0) begin
                    // keep holding a pending request
                end else if ($urandom_range(0, 2) != 0) begin
                    set_req(c, 17'($urandom), 1'($urandom), 8'($urandom));
                end else begin
                    req[c] = 1'b0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
